// File: rtl/filter_pkg.sv
// Shared types and sizing helpers for the filter scratchpad loader.
package filter_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      FILL = 2'd1,
      FULL = 2'd2
   } state_t;

   // Input-stall watchdog limit and counter width (error build only)
   localparam int unsigned STALL_LIMIT = 255;
   localparam int unsigned STALL_W     = 8;

   function automatic int unsigned calc_num_slots(input int unsigned cells,
                                                  input int unsigned fsize);
      return cells / fsize;
   endfunction

   // Index width that never collapses to zero bits
   function automatic int unsigned idx_width(input int unsigned n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

endpackage

// File: rtl/filter_slot_ring.sv
// Circular slot bookkeeping: write/read slot pointers, resident-filter count, flags.
module filter_slot_ring
   import filter_pkg::*;
#(
   parameter int unsigned NUM_SLOTS = 2,
   parameter int unsigned SLOT_W    = 1,
   parameter int unsigned OCC_W     = 2
)(
   input  logic              clk,
   input  logic              rst,
   input  logic              complete,
   input  logic              rel_pulse,
   output logic [SLOT_W-1:0] wr_slot,
   output logic [SLOT_W-1:0] rd_slot,
   output logic [OCC_W-1:0]  occupancy,
   output logic              empty,
   output logic              full_next
);

   logic             do_rel;
   logic [OCC_W-1:0] occ_next;

   function automatic logic [SLOT_W-1:0] bump(input logic [SLOT_W-1:0] s);
      return (s == SLOT_W'(NUM_SLOTS - 1)) ? '0 : SLOT_W'(s + 1'b1);
   endfunction

   // A release against an empty ring is dropped; completion and release together cancel
   always_comb begin
      do_rel   = rel_pulse && (occupancy != '0);
      occ_next = occupancy;
      if (complete && !do_rel)
         occ_next = OCC_W'(occupancy + 1'b1);
      else if (!complete && do_rel)
         occ_next = OCC_W'(occupancy - 1'b1);
   end

   assign empty     = (occupancy == '0);
   assign full_next = (occ_next == OCC_W'(NUM_SLOTS));

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wr_slot   <= '0;
         rd_slot   <= '0;
         occupancy <= '0;
      end else begin
         if (complete) wr_slot <= bump(wr_slot);
         if (do_rel)   rd_slot <= bump(rd_slot);
         occupancy <= occ_next;
      end
   end

endmodule

// File: rtl/filter_scratch_loader.sv
// Streams filter words into fixed-size scratchpad slots used as a circular buffer.
// Define FILTER_SCRATCH_LOADER_ERR_EN to add the sticky err output.
module filter_scratch_loader
   import filter_pkg::*;
#(
   parameter int unsigned SCRATCH_WIDTH        = 8,
   parameter int unsigned SCRATCH_ADDRESS_SIZE = 8,
   parameter int unsigned CELL_NUMS            = 8,
   parameter int unsigned FILTER_SIZE          = 4
)(
   input  logic                                      clk,
   input  logic                                      rst,
   input  logic                                      en,
   input  logic [SCRATCH_WIDTH-1:0]                  in_data,
   input  logic                                      in_valid,
   output logic                                      in_ready,
   output logic                                      sp_write_en,
   output logic [SCRATCH_ADDRESS_SIZE-1:0]           sp_write_addr,
   output logic [SCRATCH_WIDTH-1:0]                  sp_data_in,
   output logic                                      filter_ready,
   output logic [SCRATCH_ADDRESS_SIZE-1:0]           filter_base,
   input  logic                                      filter_release,
   output logic [$clog2(CELL_NUMS/FILTER_SIZE+1)-1:0] occupancy
`ifdef FILTER_SCRATCH_LOADER_ERR_EN
   ,
   output logic                                      err
`endif
);

   localparam int unsigned NUM_SLOTS = calc_num_slots(CELL_NUMS, FILTER_SIZE);
   localparam int unsigned SLOT_W    = idx_width(NUM_SLOTS);
   localparam int unsigned WORD_W    = idx_width(FILTER_SIZE);
   localparam int unsigned OCC_W     = $clog2(NUM_SLOTS + 1);

   state_t            state, state_next;
   logic [WORD_W-1:0] word_cnt;
   logic [SLOT_W-1:0] wr_slot, rd_slot;
   logic              accept, last_word, complete;
   logic              empty, full_next;

   assign accept    = in_valid && (state == FILL);
   assign last_word = (word_cnt == WORD_W'(FILTER_SIZE - 1));
   assign complete  = accept && last_word;

   filter_slot_ring #(
      .NUM_SLOTS (NUM_SLOTS),
      .SLOT_W    (SLOT_W),
      .OCC_W     (OCC_W)
   ) u_ring (
      .clk       (clk),
      .rst       (rst),
      .complete  (complete),
      .rel_pulse (filter_release),
      .wr_slot   (wr_slot),
      .rd_slot   (rd_slot),
      .occupancy (occupancy),
      .empty     (empty),
      .full_next (full_next)
   );

   always_ff @(posedge clk or posedge rst) begin
      if (rst) state <= IDLE;
      else     state <= state_next;
   end

   // Next state looks at the occupancy the ring will hold after this edge
   always_comb begin
      state_next = state;
      if (!en)
         state_next = IDLE;
      else if (full_next)
         state_next = FULL;
      else
         state_next = FILL;
   end

   // Write path is combinational so the scratchpad captures on the accepting edge
   always_comb begin
      in_ready      = 1'b0;
      sp_write_en   = 1'b0;
      sp_write_addr = '0;
      sp_data_in    = '0;
      in_ready      = (state == FILL);
      if (accept) begin
         sp_write_en   = 1'b1;
         sp_write_addr = SCRATCH_ADDRESS_SIZE'(32'(wr_slot) * FILTER_SIZE + 32'(word_cnt));
         sp_data_in    = in_data;
      end
   end

   // Word position is held while en is low so a partial filter resumes in place
   always_ff @(posedge clk or posedge rst) begin
      if (rst)
         word_cnt <= '0;
      else if (accept)
         word_cnt <= last_word ? '0 : WORD_W'(word_cnt + 1'b1);
   end

   assign filter_ready = !empty;
   assign filter_base  = SCRATCH_ADDRESS_SIZE'(32'(rd_slot) * FILTER_SIZE);

`ifdef FILTER_SCRATCH_LOADER_ERR_EN
   logic [STALL_W-1:0] stall_cnt;
   logic               stall_hit;
   logic               bad_release;

   assign stall_hit   = (state == FULL) && in_valid;
   assign bad_release = filter_release && empty;

   // Sticky error: illegal release, or producer stalled against a full ring too long
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         stall_cnt <= '0;
         err       <= 1'b0;
      end else begin
         if (!stall_hit)
            stall_cnt <= '0;
         else if (stall_cnt != STALL_W'(STALL_LIMIT))
            stall_cnt <= STALL_W'(stall_cnt + 1'b1);
         if (bad_release || (stall_hit && (stall_cnt == STALL_W'(STALL_LIMIT))))
            err <= 1'b1;
      end
   end
`endif

endmodule

// File: tb/tb_filter_scratch_loader.sv
// Scoreboard bench for filter_scratch_loader at default parameters (2 slots of 4 words).
module tb_filter_scratch_loader;

   logic       clk = 1'b0;
   logic       rst, en, in_valid, in_ready, sp_write_en;
   logic       filter_ready, filter_release;
   logic [7:0] in_data, sp_write_addr, sp_data_in, filter_base;
   logic [1:0] occupancy;
`ifdef FILTER_SCRATCH_LOADER_ERR_EN
   logic       err;
`endif

   int          n_cmp = 0;
   int          n_bad = 0;
   logic [15:0] exp_q[$];
   logic [15:0] exp_w;

   always #5 clk = ~clk;

   filter_scratch_loader dut (
      .clk            (clk),
      .rst            (rst),
      .en             (en),
      .in_data        (in_data),
      .in_valid       (in_valid),
      .in_ready       (in_ready),
      .sp_write_en    (sp_write_en),
      .sp_write_addr  (sp_write_addr),
      .sp_data_in     (sp_data_in),
      .filter_ready   (filter_ready),
      .filter_base    (filter_base),
      .filter_release (filter_release),
      .occupancy      (occupancy)
`ifdef FILTER_SCRATCH_LOADER_ERR_EN
      ,
      .err            (err)
`endif
   );

   // Every scratchpad write must match the oldest expected {addr,data}
   always @(negedge clk) begin
      if (sp_write_en) begin
         n_cmp++;
         if (exp_q.size() == 0) begin
            n_bad++;
            $display("FAIL unexpected_write: got addr=%0d data=%h, expected no write",
                     sp_write_addr, sp_data_in);
         end else begin
            exp_w = exp_q.pop_front();
            if ({sp_write_addr, sp_data_in} !== exp_w) begin
               n_bad++;
               $display("FAIL write: got addr=%0d data=%h, expected addr=%0d data=%h",
                        sp_write_addr, sp_data_in, exp_w[15:8], exp_w[7:0]);
            end
         end
      end
   end

   initial begin
      #100000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end

   // Entered at posedge+1; returns at posedge+1 after the accepting edge
   task automatic send_word(input logic [7:0] d, input logic [7:0] a, input logic rel);
      int          waited = 0;
      logic [15:0] dummy;
      exp_q.push_back({a, d});
      in_data = d; in_valid = 1'b1; filter_release = rel;
      @(negedge clk);
      while (!in_ready && waited < 20) begin
         waited++;
         @(negedge clk);
      end
      if (!in_ready) begin
         n_cmp++; n_bad++;
         $display("FAIL send_timeout: in_ready=%b for word %h, expected 1", in_ready, d);
         dummy = exp_q.pop_back();
      end
      @(posedge clk); #1;
      in_valid = 1'b0; filter_release = 1'b0; in_data = 8'h00;
   endtask

   task automatic pulse_release();
      filter_release = 1'b1;
      @(posedge clk); #1;
      filter_release = 1'b0;
   endtask

   task automatic test_reset();
      rst = 1'b1; en = 1'b0; in_valid = 1'b0; in_data = 8'h00; filter_release = 1'b0;
      #2;
      n_cmp++; if (in_ready !== 1'b0)      begin n_bad++; $display("FAIL reset_in_ready: got %b, expected 0", in_ready); end
      n_cmp++; if (sp_write_en !== 1'b0)   begin n_bad++; $display("FAIL reset_write_en: got %b, expected 0", sp_write_en); end
      n_cmp++; if (sp_write_addr !== 8'd0) begin n_bad++; $display("FAIL reset_write_addr: got %0d, expected 0", sp_write_addr); end
      n_cmp++; if (sp_data_in !== 8'd0)    begin n_bad++; $display("FAIL reset_data_in: got %h, expected 0", sp_data_in); end
      n_cmp++; if (filter_ready !== 1'b0)  begin n_bad++; $display("FAIL reset_filter_ready: got %b, expected 0", filter_ready); end
      n_cmp++; if (filter_base !== 8'd0)   begin n_bad++; $display("FAIL reset_filter_base: got %0d, expected 0", filter_base); end
      n_cmp++; if (occupancy !== 2'd0)     begin n_bad++; $display("FAIL reset_occupancy: got %0d, expected 0", occupancy); end
      @(posedge clk); #1;
      rst = 1'b0;
   endtask

   task automatic test_fill_one();
      en = 1'b1;
      for (int i = 0; i < 4; i++) send_word(8'(8'h11 + i), 8'(i), 1'b0);
      n_cmp++; if (filter_ready !== 1'b1) begin n_bad++; $display("FAIL fill1_ready: got %b, expected 1", filter_ready); end
      n_cmp++; if (filter_base !== 8'd0)  begin n_bad++; $display("FAIL fill1_base: got %0d, expected 0", filter_base); end
      n_cmp++; if (occupancy !== 2'd1)    begin n_bad++; $display("FAIL fill1_occupancy: got %0d, expected 1", occupancy); end
   endtask

   task automatic test_fill_capacity();
      for (int i = 0; i < 4; i++) send_word(8'(8'h21 + i), 8'(4 + i), 1'b0);
      n_cmp++; if (in_ready !== 1'b0)  begin n_bad++; $display("FAIL full_in_ready: got %b, expected 0", in_ready); end
      n_cmp++; if (occupancy !== 2'd2) begin n_bad++; $display("FAIL full_occupancy: got %0d, expected 2", occupancy); end
      n_cmp++; if (dut.state !== filter_pkg::FULL) begin n_bad++; $display("FAIL full_state: got %0d, expected FULL", dut.state); end
      // Ninth word stays pending while the ring is full
      in_data = 8'h99; in_valid = 1'b1;
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         n_cmp++;
         if (sp_write_en !== 1'b0 || in_ready !== 1'b0 || sp_data_in !== 8'h00) begin
            n_bad++;
            $display("FAIL full_pending: got we=%b rdy=%b data=%h, expected 0/0/00",
                     sp_write_en, in_ready, sp_data_in);
         end
      end
      @(posedge clk); #1;
   endtask

   task automatic test_release_wrap();
      pulse_release();
      n_cmp++; if (filter_base !== 8'd4) begin n_bad++; $display("FAIL wrap_base: got %0d, expected 4", filter_base); end
      n_cmp++; if (occupancy !== 2'd1)   begin n_bad++; $display("FAIL wrap_occupancy: got %0d, expected 1", occupancy); end
      n_cmp++; if (in_ready !== 1'b1)    begin n_bad++; $display("FAIL wrap_in_ready: got %b, expected 1", in_ready); end
      send_word(8'h99, 8'd0, 1'b0);
   endtask

   task automatic test_simultaneous();
      send_word(8'h9A, 8'd1, 1'b0);
      send_word(8'h9B, 8'd2, 1'b0);
      send_word(8'h9C, 8'd3, 1'b1);
      n_cmp++; if (occupancy !== 2'd1)    begin n_bad++; $display("FAIL simul_occupancy: got %0d, expected 1", occupancy); end
      n_cmp++; if (filter_base !== 8'd0)  begin n_bad++; $display("FAIL simul_base: got %0d, expected 0", filter_base); end
      n_cmp++; if (filter_ready !== 1'b1) begin n_bad++; $display("FAIL simul_ready: got %b, expected 1", filter_ready); end
      n_cmp++; if (in_ready !== 1'b1)     begin n_bad++; $display("FAIL simul_in_ready: got %b, expected 1", in_ready); end
   endtask

   task automatic test_en_drop();
      send_word(8'hA1, 8'd4, 1'b0);
      send_word(8'hA2, 8'd5, 1'b0);
      en = 1'b0;
      @(posedge clk); #1;
      in_data = 8'hA3; in_valid = 1'b1;
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         n_cmp++;
         if (in_ready !== 1'b0 || sp_write_en !== 1'b0) begin
            n_bad++;
            $display("FAIL en_low: got rdy=%b we=%b, expected 0/0", in_ready, sp_write_en);
         end
      end
      @(posedge clk); #1;
      en = 1'b1;
      send_word(8'hA3, 8'd6, 1'b0);
      send_word(8'hA4, 8'd7, 1'b0);
      n_cmp++; if (occupancy !== 2'd2) begin n_bad++; $display("FAIL endrop_occupancy: got %0d, expected 2", occupancy); end
      n_cmp++; if (in_ready !== 1'b0)  begin n_bad++; $display("FAIL endrop_in_ready: got %b, expected 0", in_ready); end
   endtask

   task automatic test_release_idle();
      en = 1'b0;
      pulse_release();
      n_cmp++; if (occupancy !== 2'd1 || filter_base !== 8'd4) begin
         n_bad++; $display("FAIL idle_rel1: got occ=%0d base=%0d, expected 1/4", occupancy, filter_base); end
      pulse_release();
      n_cmp++; if (occupancy !== 2'd0 || filter_base !== 8'd0 || filter_ready !== 1'b0) begin
         n_bad++; $display("FAIL idle_rel2: got occ=%0d base=%0d rdy=%b, expected 0/0/0", occupancy, filter_base, filter_ready); end
      // Release against an empty ring must not move the read pointer
      pulse_release();
      n_cmp++; if (occupancy !== 2'd0 || filter_base !== 8'd0) begin
         n_bad++; $display("FAIL empty_release: got occ=%0d base=%0d, expected 0/0", occupancy, filter_base); end
   endtask

   task automatic test_reset_mid();
      en = 1'b1;
      for (int i = 0; i < 6; i++) send_word(8'(8'hB1 + i), 8'(i), 1'b0);
      n_cmp++; if (occupancy !== 2'd1 || filter_base !== 8'd0) begin
         n_bad++; $display("FAIL pre_reset: got occ=%0d base=%0d, expected 1/0", occupancy, filter_base); end
      rst = 1'b1;
      #1;
      n_cmp++; if (occupancy !== 2'd0 || filter_ready !== 1'b0 || in_ready !== 1'b0 || sp_write_en !== 1'b0) begin
         n_bad++; $display("FAIL async_reset: got occ=%0d rdy=%b in_rdy=%b we=%b, expected all 0",
                           occupancy, filter_ready, in_ready, sp_write_en); end
      @(posedge clk); #1;
      rst = 1'b0;
      send_word(8'hC1, 8'd0, 1'b0);
      n_cmp++; if (occupancy !== 2'd0 || filter_ready !== 1'b0) begin
         n_bad++; $display("FAIL post_reset: got occ=%0d rdy=%b, expected 0/0", occupancy, filter_ready); end
   endtask

   initial begin
      test_reset();
      test_fill_one();
      test_fill_capacity();
      test_release_wrap();
      test_simultaneous();
      test_en_drop();
      test_release_idle();
      test_reset_mid();
      repeat (2) @(posedge clk);
      n_cmp++;
      if (exp_q.size() != 0) begin
         n_bad++;
         $display("FAIL leftover_writes: got %0d pending, expected 0", exp_q.size());
      end
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule

// File: doc/filter_scratch_loader.md
# filter_scratch_loader

Write-side controller for the filter scratchpad in the convolution processing element. It accepts a valid/ready stream of filter words and writes them into the scratchpad in fixed-size filter slots, addressed as a circular buffer. It tracks how many complete filters are resident and publishes the base address of the oldest one to the MAC datapath. The MAC datapath returns each slot with a release pulse.

## Interface
- SCRATCH_WIDTH, 8, filter word width
- SCRATCH_ADDRESS_SIZE, 8, scratchpad address width
- CELL_NUMS, 8, scratchpad depth in words; must be a multiple of FILTER_SIZE
- FILTER_SIZE, 4, words per filter; NUM_SLOTS = CELL_NUMS/FILTER_SIZE (must be ≥1)

Ports:
- clk  in  1  clock, rising edge
- rst  in  1  reset, asynchronous, active-high
- en  in  1  loader enable
- in_data  in  SCRATCH_WIDTH  incoming filter word
- in_valid  in  1  in_data is valid
- in_ready  out  1  loader can accept a word this cycle
- sp_write_en  out  1  scratchpad write strobe
- sp_write_addr  out  SCRATCH_ADDRESS_SIZE  scratchpad write address
- sp_data_in  out  SCRATCH_WIDTH  scratchpad write data
- filter_ready  out  1  at least one complete filter is resident
- filter_base  out  SCRATCH_ADDRESS_SIZE  base address of the oldest resident filter
- filter_release  in  1  one-cycle pulse; consumer is done with the oldest filter
- occupancy  out  clog2(NUM_SLOTS+1)  number of complete filters resident

## Operation
- Registered state:
  - word_cnt (0..FILTER_SIZE-1)
  - wr_slot (0..NUM_SLOTS-1)
  - rd_slot (0..NUM_SLOTS-1)
  - occupancy (0..NUM_SLOTS)
  - FSM state
- FSM states and transitions:
  - IDLE: entered from any state when en=0.
  - FILL: entered when en=1 and occupancy<NUM_SLOTS.
  - FULL: entered when en=1 and occupancy==NUM_SLOTS.
  - The next state is evaluated every cycle from the next-cycle values of en and occupancy.
- in_ready = (state==FILL). An accept occurs when in_valid && in_ready.
- Scratchpad write path (combinational from an accept):
  - sp_write_en = accept
  - sp_write_addr = wr_slot*FILTER_SIZE + word_cnt
  - sp_data_in = in_data
- On each accept, word_cnt increments. When word_cnt==FILTER_SIZE-1:
  - word_cnt returns to 0
  - wr_slot advances, wrapping from NUM_SLOTS-1 to 0
  - occupancy increments (filter complete)
- On filter_release with occupancy>0: rd_slot advances (with wrap) and occupancy decrements.
- Simultaneous filter completion and release: occupancy is unchanged and both pointers advance.
- filter_ready = (occupancy!=0). filter_base = rd_slot*FILTER_SIZE.
- Dropping en mid-filter: word_cnt and wr_slot are held, and loading resumes at the same address when en returns.
- filter_release is honoured in every state, including IDLE.
- filter_release with occupancy==0 is ignored: no pointer or occupancy change.

## Timing
- Reset values:
  - all counters and pointers 0; state IDLE
  - in_ready 0, sp_write_en 0, sp_write_addr 0, sp_data_in 0
  - filter_ready 0, filter_base 0, occupancy 0
- sp_data_in is forced to 0 when not writing.
- The write has zero latency: the scratchpad captures the word on the same edge the loader accepts it.
- filter_ready rises in the cycle after the accept of a filter's last word. The scratchpad already holds every word of that filter at that point.
- FULL to FILL: in_ready is 1 in the cycle after a release that frees a slot (when en=1).
- A completion in FILL that makes occupancy==NUM_SLOTS drops in_ready in the next cycle. There is no accept beyond capacity.
- Reset asserted mid-filter discards the partial filter and all resident filters immediately (asynchronous).

## Configuration
- FILTER_SCRATCH_LOADER_ERR_EN:
  - Defined: adds output err (1 bit, sticky, reset 0). err is set by filter_release while occupancy==0, or by in_valid held high in FULL for more than 255 consecutive cycles (8-bit stall counter). It is cleared only by rst.
  - Undefined: no err port, no stall counter; illegal releases are silently ignored.

## Structure
- Shared package filter_pkg holds:
  - the FSM state enum (IDLE, FILL, FULL)
  - the NUM_SLOTS derivation and the slot/word counter width constants
  - the stall-limit constant (255)
- One sub-module, filter_slot_ring, holds the wr_slot/rd_slot pointers, occupancy and the full/empty flags. The parent module holds the FSM, word_cnt and the write path.

## Test plan
All scenarios use the default parameters: FILTER_SIZE=4, CELL_NUMS=8, NUM_SLOTS=2.
- Fill one filter: en=1, stream 0x11..0x14 back-to-back -> writes to addresses 0..3; the next cycle gives filter_ready=1, filter_base=0, occupancy=1.
- Fill to capacity: stream 8 words -> addresses 0..7; in_ready=0 and state FULL after the 8th accept; a 9th word stays pending.
- Release and wrap: from full, pulse filter_release -> filter_base=4, occupancy=1, in_ready=1 next cycle; the next word writes address 0.
- Simultaneous completion and release: with occupancy=1, the last word of the second filter and a release in the same cycle -> occupancy stays 1 and filter_base advances.
- en drop mid-filter: accept 2 words, deassert en for 3 cycles, reassert -> the next word writes address 2, with no writes while en=0.
- Reset mid-operation: assert rst with occupancy=1 and word_cnt=2 -> all outputs are 0 immediately; after release of reset, the first word writes address 0.
